// File: rtl/lvda_disc_pkg.sv
// Shared types and default sizing for the LVDA discrete-input register set.
package lvda_disc_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } di_state_t;

    localparam int unsigned DI_NUM_DEF   = 12;
    localparam int unsigned DI_FILT_DEF  = 3;
    localparam int unsigned DI_WORD_BITS = 26;

endpackage

// File: rtl/di_filter.sv
// One discrete input: 2-flop synchronizer followed by a sampled debounce filter.
module di_filter
    import lvda_disc_pkg::*;
#(
    parameter int unsigned FILT_LEN = DI_FILT_DEF
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic DI,
    input  logic SMPL,
    output logic DIF
);

    localparam logic [3:0] CntLast = 4'(FILT_LEN - 1);

    logic       meta_q;
    logic       ds_q;
    logic [3:0] cnt_q, cnt_d;
    logic       dif_q, dif_d;

    // Any sample that agrees with the held state restarts the count, so bounces are rejected.
    always_comb begin
        cnt_d = cnt_q;
        dif_d = dif_q;
        if (SMPL) begin
            if (ds_q == dif_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                dif_d = ~dif_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            meta_q <= 1'b0;
            ds_q   <= 1'b0;
            cnt_q  <= '0;
            dif_q  <= 1'b0;
        end else begin
            meta_q <= DI;
            ds_q   <= meta_q;
            cnt_q  <= cnt_d;
            dif_q  <= dif_d;
        end
    end

    assign DIF = dif_q;

endmodule

// File: rtl/disc_in_regs.sv
// Discrete-input register set: filtered inputs, snapshot on read, LSB-first serial shift-out.
// Optional change interrupt (DIINT/DIPEND) is built only when DI_INTERRUPT_EN is defined.
module disc_in_regs
    import lvda_disc_pkg::*;
#(
    parameter int unsigned NUM_DI    = DI_NUM_DEF,
    parameter int unsigned FILT_LEN  = DI_FILT_DEF,
    parameter int unsigned WORD_BITS = DI_WORD_BITS
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic [NUM_DI-1:0] DI,
    input  logic              SMPL,
    input  logic              DIRD,
    input  logic              Y1,
    output logic              DIS,
    output logic              DIBSY,
    output logic [NUM_DI-1:0] DIF
`ifdef DI_INTERRUPT_EN
    ,
    output logic              DIINT,
    output logic              DIPEND
`endif
);

    localparam int unsigned        CntW    = $clog2(WORD_BITS + 1);
    localparam logic [CntW-1:0]    LastBit = CntW'(WORD_BITS - 1);

    di_state_t             state_q, state_d;
    logic [WORD_BITS-1:0]  sr_q, sr_d, sr_load;
    logic [CntW-1:0]       bitcnt_q, bitcnt_d;

    for (genvar i = 0; i < NUM_DI; i++) begin : g_filt
        di_filter #(
            .FILT_LEN (FILT_LEN)
        ) u_filt (
            .SIM_CLK (SIM_CLK),
            .SIM_RST (SIM_RST),
            .DI      (DI[i]),
            .SMPL    (SMPL),
            .DIF     (DIF[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        sr_load  = '0;
        sr_load[NUM_DI-1:0] = DIF;
        unique case (state_q)
            IDLE: begin
                // Load takes priority over a coincident Y1; no shift on the load cycle.
                if (DIRD) begin
                    sr_d     = sr_load;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (Y1) begin
                    sr_d     = sr_q >> 1;
                    bitcnt_d = bitcnt_q + CntW'(1);
                    if (bitcnt_q == LastBit) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign DIBSY = (state_q == SHIFT);
    assign DIS   = DIBSY & sr_q[0];

`ifdef DI_INTERRUPT_EN
    logic              load;
    logic              toggle;
    logic [NUM_DI-1:0] dif_prev_q;
    logic              int_q;
    logic              pend_q;

    assign load   = (state_q == IDLE) && DIRD;
    assign toggle = |(DIF ^ dif_prev_q);

    // A change seen in the same cycle as a read load keeps the pending flag set.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            dif_prev_q <= '0;
            int_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            dif_prev_q <= DIF;
            int_q      <= toggle;
            pend_q     <= toggle | (pend_q & ~load);
        end
    end

    assign DIINT  = int_q;
    assign DIPEND = pend_q;
`endif

endmodule

// File: tb/tb_disc_in_regs.sv
// Self-checking bench for disc_in_regs: behavioural model plus directed literal checks.
module tb_disc_in_regs;

    localparam int NUM_DI    = 12;
    localparam int FILT_LEN  = 3;
    localparam int WORD_BITS = 26;

    logic              SIM_CLK;
    logic              SIM_RST;
    logic [NUM_DI-1:0] DI;
    logic              SMPL;
    logic              DIRD;
    logic              Y1;
    logic              DIS;
    logic              DIBSY;
    logic [NUM_DI-1:0] DIF;
`ifdef DI_INTERRUPT_EN
    logic              DIINT;
    logic              DIPEND;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    disc_in_regs #(
        .NUM_DI    (NUM_DI),
        .FILT_LEN  (FILT_LEN),
        .WORD_BITS (WORD_BITS)
    ) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .DI      (DI),
        .SMPL    (SMPL),
        .DIRD    (DIRD),
        .Y1      (Y1),
        .DIS     (DIS),
        .DIBSY   (DIBSY),
        .DIF     (DIF)
`ifdef DI_INTERRUPT_EN
        ,
        .DIINT   (DIINT),
        .DIPEND  (DIPEND)
`endif
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NUM_DI-1:0] s1_m, s2_m, dif_m, word_m;
    int                run_m [NUM_DI];
    bit                busy_m;
    int                k_m;
    bit                tog_m, int_m, pend_m;

    always @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            s1_m = '0; s2_m = '0; dif_m = '0; word_m = '0;
            for (int i = 0; i < NUM_DI; i++) run_m[i] = 0;
            busy_m = 0; k_m = 0; tog_m = 0; int_m = 0; pend_m = 0;
        end else begin
            logic [NUM_DI-1:0] nd;
            bit                load_now;
            nd = dif_m;
            // Count consecutive differing samples; accept after FILT_LEN of them.
            if (SMPL) begin
                for (int i = 0; i < NUM_DI; i++) begin
                    if (s2_m[i] != dif_m[i]) begin
                        run_m[i]++;
                        if (run_m[i] == FILT_LEN) begin
                            nd[i] = ~dif_m[i];
                            run_m[i] = 0;
                        end
                    end else begin
                        run_m[i] = 0;
                    end
                end
            end
            s2_m = s1_m;
            s1_m = DI;
            load_now = !busy_m && DIRD;
            if (load_now) begin
                word_m = dif_m;
                k_m    = 0;
                busy_m = 1;
            end else if (busy_m && Y1) begin
                k_m++;
                if (k_m == WORD_BITS) busy_m = 0;
            end
            int_m  = tog_m;
            pend_m = tog_m ? 1'b1 : (load_now ? 1'b0 : pend_m);
            tog_m  = (nd != dif_m);
            dif_m  = nd;
        end
    end

    always @(posedge SIM_CLK) begin
        #1;
        if (SIM_RST) begin
            check("model_dif", 32'(DIF), 32'(dif_m));
            check("model_bsy", 32'(DIBSY), 32'(busy_m));
            check("model_dis", 32'(DIS), 32'((busy_m && k_m < NUM_DI) ? word_m[k_m] : 1'b0));
`ifdef DI_INTERRUPT_EN
            check("model_int", 32'(DIINT), 32'(int_m));
            check("model_pend", 32'(DIPEND), 32'(pend_m));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // Apply strobes for one clock; return at the next falling edge with outputs settled.
    task automatic cyc(input logic rd, input logic y, input logic sm);
        DIRD = rd; Y1 = y; SMPL = sm;
        @(negedge SIM_CLK);
        DIRD = 0; Y1 = 0; SMPL = 0;
    endtask

    task automatic set_dif(input logic [NUM_DI-1:0] v);
        DI = v;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        repeat (FILT_LEN) cyc(0, 0, 1);
        check("set_dif", 32'(DIF), 32'(v));
    endtask

    // Shift a full word after the load, checking every bit against w.
    task automatic shift_word(input string name, input logic [NUM_DI-1:0] w, input bit gaps,
                              input int rd_at);
        for (int k = 1; k <= WORD_BITS; k++) begin
            if (gaps && (k % 2 == 1)) cyc(0, 0, 0);
            cyc(k == rd_at, 1, 0);
            if (k < WORD_BITS) begin
                check({name, "_dis"}, 32'(DIS), 32'((k < NUM_DI) ? w[k] : 1'b0));
                check({name, "_bsy"}, 32'(DIBSY), 32'd1);
            end else begin
                check({name, "_end_bsy"}, 32'(DIBSY), 32'd0);
                check({name, "_end_dis"}, 32'(DIS), 32'd0);
            end
        end
    endtask

    logic [NUM_DI-1:0] w;

    initial begin
        SIM_RST = 0; DI = '0; SMPL = 0; DIRD = 0; Y1 = 0;
        #2;
        check("rst_dis", 32'(DIS), 32'd0);
        check("rst_bsy", 32'(DIBSY), 32'd0);
        check("rst_dif", 32'(DIF), 32'd0);
        @(negedge SIM_CLK);
        SIM_RST = 1;
        cyc(0, 0, 0);

        // Filter: two-sample glitch rejected, three-sample level accepted.
        DI[0] = 1'b1;
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 1);
        DI[0] = 1'b0;
        cyc(0, 0, 0); cyc(0, 0, 0);
        repeat (4) cyc(0, 0, 1);
        check("glitch_dif0", 32'(DIF[0]), 32'd0);
        DI[0] = 1'b1;
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 1);
        check("filt_2nd", 32'(DIF[0]), 32'd0);
        cyc(0, 0, 1);
        check("filt_3rd", 32'(DIF[0]), 32'd1);

        // Read of 12'hA5C with a DIRD collision at Y1 #5.
        w = 12'hA5C;
        set_dif(w);
        cyc(1, 0, 0);
        check("rd_bsy", 32'(DIBSY), 32'd1);
        check("rd_bit0", 32'(DIS), 32'(w[0]));
        shift_word("rd", w, 1, 5);

        // DIRD coincident with Y1 in IDLE: load wins, bit 0 presented for one clock.
        w = 12'h3A5;
        set_dif(w);
        cyc(1, 1, 0);
        check("co_bsy", 32'(DIBSY), 32'd1);
        check("co_bit0", 32'(DIS), 32'd1);
        shift_word("co", w, 0, 0);

        // Snapshot: DIF[3] changes mid-word, word keeps the old value.
        cyc(1, 0, 0);
        cyc(0, 1, 0); cyc(0, 1, 0);
        set_dif(12'h3AD);
        cyc(0, 1, 0);
        check("snap_old_b3", 32'(DIS), 32'd0);
        for (int k = 4; k <= WORD_BITS; k++) cyc(0, 1, 0);
        check("snap_done", 32'(DIBSY), 32'd0);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        check("snap_new_b3", 32'(DIS), 32'd1);
        for (int k = 4; k <= WORD_BITS; k++) cyc(0, 1, 0);

`ifdef DI_INTERRUPT_EN
        DI[7] = ~DI[7];
        cyc(0, 0, 0); cyc(0, 0, 0);
        repeat (FILT_LEN) cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("int_pulse", 32'(DIINT), 32'd1);
        check("int_pend", 32'(DIPEND), 32'd1);
        cyc(0, 0, 0);
        check("int_low", 32'(DIINT), 32'd0);
        cyc(1, 0, 0);
        check("pend_clr", 32'(DIPEND), 32'd0);
        repeat (WORD_BITS) cyc(0, 1, 0);
`endif

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) DI[$urandom_range(0, NUM_DI - 1)] ^= 1'b1;
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0);
        end

        // Reset mid-transfer with all inputs high.
        set_dif(12'hFFF);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        check("pre_rst_bsy", 32'(DIBSY), 32'd1);
        #2 SIM_RST = 0;
        #1;
        check("arst_dis", 32'(DIS), 32'd0);
        check("arst_bsy", 32'(DIBSY), 32'd0);
        check("arst_dif", 32'(DIF), 32'd0);
        @(negedge SIM_CLK);
        SIM_RST = 1;
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 1);
        check("post_rst_2", 32'(DIF), 32'd0);
        check("post_rst_bsy", 32'(DIBSY), 32'd0);
        cyc(0, 0, 1);
        check("post_rst_3", 32'(DIF), 32'hFFF);
        cyc(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
